// File: rtl/canvas_display_reader.sv
// ============================================================================
// canvas_display_reader
// Walks the VGA raster, reads the 320x240 canvas BRAM with 2x doubling and
// decodes each canvas byte to RGB444 with sync delayed to match.
// Revision: 1.0
// ============================================================================
`default_nettype none

module canvas_display_reader #(
  parameter int BRAM_LATENCY = 2,
  parameter int BLINK_FRAMES = 15
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blank_in,
  input  logic        canvas_only,
  input  logic [7:0]  pixel_from_bram,
  output logic [16:0] pixel_addr_forvga,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs
);

  localparam int          c_LATENCY    = BRAM_LATENCY + 2;
  localparam int          c_CNT_W      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [16:0] c_ROW_STRIDE = 17'd320;

  logic [8:0]           w_sy;
  logic [9:0]           w_sx;
  logic                 w_active;
  logic [16:0]          w_row_base;
  logic [16:0]          r_row_base;
  logic [8:0]           r_row_sy;
  logic [16:0]          r_addr;
  logic [c_LATENCY-1:0] r_hs_pipe;
  logic [c_LATENCY-1:0] r_vs_pipe;
  logic [c_LATENCY-2:0] r_act_pipe;
  logic [11:0]          w_rgb;
  logic [11:0]          r_rgb;
  logic [c_CNT_W-1:0]   r_frame_cnt;
  logic                 r_blink;

  assign w_sy     = vcount_in[9:1];
  assign w_sx     = hcount_in[10:1];
  assign w_active = (hcount_in < 11'd640) && (vcount_in < 10'd480) && !blank_in;

  // Row base follows the raster even through reset, so a mid-frame reset
  // resumes with correct addresses without waiting for the next frame.
  always_comb begin
    w_row_base = r_row_base;
    if (vcount_in == 10'd0) begin
      w_row_base = 17'd0;
    end else if (w_sy == r_row_sy + 9'd1) begin
      w_row_base = r_row_base + c_ROW_STRIDE;
    end
  end

  always_ff @(posedge clk_in) begin
    r_row_base <= w_row_base;
    r_row_sy   <= w_sy;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_addr <= 17'd0;
    end else if (w_active) begin
      r_addr <= w_row_base + {7'd0, w_sx};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_hs_pipe  <= '1;
      r_vs_pipe  <= '1;
      r_act_pipe <= '0;
    end else begin
      r_hs_pipe  <= {r_hs_pipe[c_LATENCY-2:0], hsync_in};
      r_vs_pipe  <= {r_vs_pipe[c_LATENCY-2:0], vsync_in};
      r_act_pipe <= {r_act_pipe[c_LATENCY-3:0], w_active};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_frame_cnt <= '0;
      r_blink     <= 1'b1;
    end else if (hcount_in == 11'd0 && vcount_in == 10'd480) begin
      if (r_frame_cnt == c_CNT_W'(BLINK_FRAMES - 1)) begin
        r_frame_cnt <= '0;
        r_blink     <= ~r_blink;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_rgb = 12'h000;
    case (pixel_from_bram[7:6])
      2'b11: begin
        case (pixel_from_bram[1:0])
          2'b00:   w_rgb = 12'hFF0;
          2'b01:   w_rgb = 12'hF6C;
          2'b10:   w_rgb = 12'h0F0;
          default: w_rgb = 12'hF00;
        endcase
      end
      2'b10:   if (!canvas_only) w_rgb = 12'h00F;
      2'b01:   if (!canvas_only && r_blink) w_rgb = 12'hFFF;
      default: if (!canvas_only) w_rgb = {3{pixel_from_bram[5:2]}};
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_rgb <= 12'h000;
    end else begin
      r_rgb <= r_act_pipe[c_LATENCY-2] ? w_rgb : 12'h000;
    end
  end

  assign pixel_addr_forvga = r_addr;
  assign vga_r             = r_rgb[11:8];
  assign vga_g             = r_rgb[7:4];
  assign vga_b             = r_rgb[3:0];
  assign vga_hs            = r_hs_pipe[c_LATENCY-1];
  assign vga_vs            = r_vs_pipe[c_LATENCY-1];

endmodule

`default_nettype wire

// File: tb/tb_canvas_display_reader.sv
// ============================================================================
// tb_canvas_display_reader
// Randomised raster bench with a BRAM model and an arithmetic reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_canvas_display_reader;

  localparam int BRAM_LATENCY = 2;
  localparam int BLINK_FRAMES = 15;
  localparam int L            = BRAM_LATENCY + 2;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        hsync_in, vsync_in, blank_in, canvas_only;
  logic [7:0]  pixel_from_bram;
  logic [16:0] pixel_addr_forvga;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs;

  always #5 clk_in = ~clk_in;

  canvas_display_reader #(
    .BRAM_LATENCY(BRAM_LATENCY),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .hcount_in        (hcount_in),
    .vcount_in        (vcount_in),
    .hsync_in         (hsync_in),
    .vsync_in         (vsync_in),
    .blank_in         (blank_in),
    .canvas_only      (canvas_only),
    .pixel_from_bram  (pixel_from_bram),
    .pixel_addr_forvga(pixel_addr_forvga),
    .vga_r            (vga_r),
    .vga_g            (vga_g),
    .vga_b            (vga_b),
    .vga_hs           (vga_hs),
    .vga_vs           (vga_vs)
  );

  // Canvas BRAM display port
  logic [7:0] mem [0:76799];
  logic [7:0] bram_pipe [BRAM_LATENCY];

  always @(posedge clk_in) begin
    bram_pipe[0] <= (pixel_addr_forvga < 17'd76800) ? mem[pixel_addr_forvga] : 8'h00;
    for (int i = 1; i < BRAM_LATENCY; i++) bram_pipe[i] <= bram_pipe[i-1];
  end
  assign pixel_from_bram = bram_pipe[BRAM_LATENCY-1];

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic [16:0] addr;
  } exp_t;

  exp_t        q[$];
  int          frame_ends;
  logic [16:0] last_addr;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [11:0] ref_rgb(input logic [7:0] d, input logic co, input logic ph);
    logic [3:0] y;
    if (d[7:6] == 2'b11) begin
      if (d[1:0] == 2'd0) return 12'hFF0;
      if (d[1:0] == 2'd1) return 12'hF6C;
      if (d[1:0] == 2'd2) return 12'h0F0;
      return 12'hF00;
    end
    if (co) return 12'h000;
    if (d[7:6] == 2'b10) return 12'h00F;
    if (d[7:6] == 2'b01) return ph ? 12'hFFF : 12'h000;
    y = 4'(d[5:0] / 4);
    return {y, y, y};
  endfunction

  // One raster cycle: check outputs owed from earlier cycles, then drive new inputs.
  task automatic tick(input int h, input int v, input logic bl, input logic rst);
    exp_t e;
    logic act;
    logic ph;
    @(negedge clk_in);
    if (q.size() >= L) begin
      e = q[q.size()-L];
      check("rgb", {vga_r, vga_g, vga_b}, e.rgb);
      check("hs", vga_hs, e.hs);
      check("vs", vga_vs, e.vs);
      check("addr", pixel_addr_forvga, q[q.size()-1].addr);
    end
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    blank_in  = bl;
    rst_in    = rst;
    hsync_in  = 1'($urandom);
    vsync_in  = 1'($urandom);
    if (rst) begin
      frame_ends = 0;
      last_addr  = 17'd0;
      q.delete();
      e = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, addr: 17'd0};
      repeat (L) q.push_back(e);
    end else begin
      act = (h < 640) && (v < 480) && !bl;
      if (act) last_addr = 17'((v / 2) * 320 + h / 2);
      if (h == 0 && v == 480) frame_ends++;
      ph     = ((frame_ends / BLINK_FRAMES) % 2) == 0;
      e.rgb  = act ? ref_rgb(mem[last_addr], canvas_only, ph) : 12'h000;
      e.hs   = hsync_in;
      e.vs   = vsync_in;
      e.addr = last_addr;
      q.push_back(e);
      if (q.size() > L + 1) void'(q.pop_front());
    end
  endtask

  task automatic lit_addr(input string tag, input int h, input int v, input logic bl,
                          input logic [16:0] want);
    tick(h, v, bl, 1'b0);
    @(posedge clk_in); #1;
    check(tag, pixel_addr_forvga, want);
  endtask

  task automatic lit_pixel(input string tag, input int h, input int v, input logic [7:0] d,
                           input logic co, input logic [11:0] want);
    repeat (L) tick(700, v, 1'b1, 1'b0);
    mem[(v / 2) * 320 + h / 2] = d;
    canvas_only = co;
    tick(h, v, 1'b0, 1'b0);
    repeat (L-1) tick(700, v, 1'b1, 1'b0);
    @(posedge clk_in); #1;
    check(tag, {vga_r, vga_g, vga_b}, want);
  endtask

  initial begin
    rst_in = 1'b1; hcount_in = '0; vcount_in = '0; hsync_in = 1'b1; vsync_in = 1'b1;
    blank_in = 1'b1; canvas_only = 1'b0; frame_ends = 0; last_addr = '0;
    for (int i = 0; i < 76800; i++) mem[i] = 8'($urandom);

    repeat (3) tick(0, 0, 1'b1, 1'b1);
    repeat (L) tick(700, 0, 1'b1, 1'b0);

    // Pixel doubling and row stepping
    for (int v = 0; v < 2; v++) begin
      lit_addr("addr_h0", 0, v, 1'b0, 17'd0);
      lit_addr("addr_h1", 1, v, 1'b0, 17'd0);
      lit_addr("addr_h2", 2, v, 1'b0, 17'd1);
      lit_addr("addr_h3", 3, v, 1'b0, 17'd1);
    end
    lit_addr("addr_v2", 2, 2, 1'b0, 17'd321);
    for (int v = 3; v < 479; v++) tick(0, v, 1'b0, 1'b0);
    lit_addr("addr_last", 639, 479, 1'b0, 17'd76799);
    lit_addr("hold_h700", 700, 479, 1'b0, 17'd76799);
    lit_addr("hold_blank", 100, 479, 1'b1, 17'd76799);
    repeat (L) tick(700, 479, 1'b1, 1'b0);
    tick(0, 480, 1'b1, 1'b0);

    // Decode
    lit_pixel("dec_C2", 0, 0, 8'hC2, 1'b0, 12'h0F0);
    lit_pixel("luma_3C", 2, 0, 8'h3C, 1'b0, 12'hFFF);
    lit_pixel("luma_14", 4, 0, 8'h14, 1'b0, 12'h555);
    lit_pixel("thr_80", 6, 0, 8'h80, 1'b0, 12'h00F);
    lit_pixel("co_3C", 2, 0, 8'h3C, 1'b1, 12'h000);
    lit_pixel("co_14", 4, 0, 8'h14, 1'b1, 12'h000);
    lit_pixel("co_80", 6, 0, 8'h80, 1'b1, 12'h000);
    lit_pixel("co_C3", 8, 0, 8'hC3, 1'b1, 12'hF00);
    canvas_only = 1'b0;

    // Mid-line reset
    for (int h = 10; h < 30; h++) tick(h, 0, 1'b0, 1'b0);
    tick(30, 0, 1'b0, 1'b1);
    @(posedge clk_in); #1;
    check("rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
    check("rst_hs", vga_hs, 1'b1);
    check("rst_vs", vga_vs, 1'b1);
    check("rst_addr", pixel_addr_forvga, 17'd0);
    for (int h = 32; h < 60; h++) tick(h, 0, 1'b0, 1'b0);
    lit_pixel("post_rst", 62, 0, 8'hC0, 1'b0, 12'hFF0);

    // Crosshair blink across frames
    for (int f = 0; f <= 30; f++) begin
      lit_pixel("blink", 0, 0, 8'h40, 1'b0, (f < 15 || f == 30) ? 12'hFFF : 12'h000);
      repeat (L) tick(700, 0, 1'b1, 1'b0);
      tick(0, 480, 1'b1, 1'b0);
    end

    // Randomised compressed frames
    for (int fr = 0; fr < 2; fr++) begin
      repeat (L) tick(700, 0, 1'b1, 1'b0);
      canvas_only = (fr == 1);
      for (int v = 0; v < 480; v++) begin
        tick(0, v, 1'b0, 1'b0);
        repeat (3) tick($urandom_range(0, 639), v, ($urandom_range(0, 9) == 0), 1'b0);
        if (v == 479) tick(639, v, 1'b0, 1'b0);
        tick(700, v, 1'b0, 1'b0);
        repeat (L) tick(700, v, 1'b1, 1'b0);
      end
      tick(0, 480, 1'b1, 1'b0);
    end
    repeat (L + 1) tick(700, 480, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
